// File: rtl/mem_access_unit.sv
// mem_access_unit: EX->WB memory access stage driving a valid/ready request and awaiting a response.
// Build option MEM_TIMEOUT_EN: abort a WAIT that sees no response within TIMEOUT cycles.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic [4:0]        rd_in,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              req_valid,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);
  // state | meaning: IDLE accept op | REQ request driven | WAIT await response | DONE write-back pulse
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d, wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d, err_q, err_d;
  logic [4:0]        wb_rd_q, wb_rd_d, rd_q, rd_d;
  logic              m2r_q, m2r_d, rw_q, rw_d, mr_q, mr_d;
  logic              is_mem, bad_op, legal_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign is_mem    = mem_read | mem_write;
  assign bad_op    = (mem_read & mem_write) | (alu_result[1:0] != 2'b00);
  assign legal_mem = is_mem & ~bad_op;
  assign stall     = (state_q == REQ) || (state_q == WAIT) ||
                     ((state_q == IDLE) && ctrl_valid && legal_mem);

  assign req_valid    = req_valid_q;
  assign req_we       = req_we_q;
  assign req_addr     = req_addr_q;
  assign req_wdata    = req_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err          = err_q;

  always_comb begin
    state_d        = state_q;
    req_valid_d    = req_valid_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    err_d          = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    rd_d           = rd_q;
    m2r_d          = m2r_q;
    rw_d           = rw_q;
    mr_d           = mr_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctrl_valid) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_result;
            wb_reg_write_d = reg_write;
            wb_rd_d        = rd_in;
          end else if (bad_op) begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
            wb_rd_d    = rd_in;
          end else begin
            req_valid_d = 1'b1;
            req_we_d    = mem_write;
            req_addr_d  = alu_result;
            req_wdata_d = store_data;
            rd_d        = rd_in;
            m2r_d       = mem_to_reg;
            rw_d        = reg_write;
            mr_d        = mem_read;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          // req_addr_q still holds the latched alu_result for non-load write-back
          state_d        = DONE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_data_d      = m2r_q ? rsp_rdata : req_addr_q;
          wb_reg_write_d = rw_q & mr_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_valid_q    <= 1'b0;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      err_q          <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      rd_q           <= '0;
      m2r_q          <= 1'b0;
      rw_q           <= 1'b0;
      mr_q           <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      req_valid_q    <= req_valid_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      err_q          <= err_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      rd_q           <= rd_d;
      m2r_q          <= m2r_d;
      rw_q           <= rw_d;
      mr_q           <= mr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected write-backs are queued at issue and checked on wb_valid.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, ctrl_valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [4:0]  rd_in, wb_rd;
  logic [31:0] alu_result, store_data, req_addr, req_wdata, rsp_rdata, wb_data;
  logic        stall, req_valid, req_we, req_ready, rsp_valid, wb_valid, wb_reg_write, err;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd_in(rd_in), .alu_result(alu_result),
    .store_data(store_data), .stall(stall), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic [31:0] addr, input logic [31:0] sdata);
    ctrl_valid = 1'b1; rd_in = rd; mem_read = mr; mem_write = mw;
    mem_to_reg = m2r; reg_write = rw; alu_result = addr; store_data = sdata;
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] d, input logic rw, input logic e);
    exp_t x;
    x.rd = rd; x.data = d; x.rw = rw; x.err = e;
    return x;
  endfunction

  // write-back monitor; error entries only carry err and reg_write expectations
  always @(negedge clk) begin
    if (!rst && err && !wb_valid) chk("err_without_wb", 1, 0);
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_err", err, e.err);
        chk("wb_reg_write", wb_reg_write, e.rw);
        if (!e.err) begin
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int dr, ds;
    rst = 1'b1; ctrl_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    rd_in = 0; alu_result = 0; store_data = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_outs", {req_we, wb_reg_write, req_addr, wb_data}, 0);
    chk("rst_stall", stall, 0);
    cyc(); rst = 1'b0;

    // ALU-only op
    cyc(); issue(5, 0, 0, 0, 1, 32'h1234, 0); exp_q.push_back(mk(5, 32'h1234, 1, 0));
    @(negedge clk); chk("alu_stall0", stall, 0);
    cyc(); ctrl_valid = 0;
    @(negedge clk); chk("alu_wb_valid", wb_valid, 1); chk("alu_stall1", stall, 0);
    chk("alu_req_valid", req_valid, 0);

    // lw, best case
    cyc(); issue(7, 1, 0, 1, 1, 32'h100, 0); req_ready = 1;
    exp_q.push_back(mk(7, 32'hDEADBEEF, 1, 0));
    @(negedge clk); chk("lw_stall0", stall, 1); chk("lw_rv0", req_valid, 0);
    cyc(); ctrl_valid = 0;
    @(negedge clk); chk("lw_rv1", req_valid, 1); chk("lw_we", req_we, 0);
    chk("lw_addr", req_addr, 32'h100); chk("lw_stall1", stall, 1);
    cyc(); req_ready = 0; rsp_valid = 1; rsp_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("lw_rv2", req_valid, 0); chk("lw_stall2", stall, 1);
    cyc(); rsp_valid = 0;
    @(negedge clk); chk("lw_wb_valid3", wb_valid, 1); chk("lw_stall3", stall, 0);

    // sw with req_ready delayed 3 cycles
    cyc(); issue(9, 0, 1, 0, 0, 32'h204, 32'hCAFE); exp_q.push_back(mk(9, 32'h204, 0, 0));
    @(negedge clk);
    cyc(); ctrl_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) req_ready = 1;
      @(negedge clk);
      chk("sw_rv", req_valid, 1); chk("sw_we", req_we, 1);
      chk("sw_addr", req_addr, 32'h204); chk("sw_wdata", req_wdata, 32'hCAFE);
      cyc();
    end
    req_ready = 0; rsp_valid = 1;
    @(negedge clk); chk("sw_rv_drop", req_valid, 0);
    cyc(); rsp_valid = 0;
    @(negedge clk); chk("sw_wb_valid", wb_valid, 1);

    // misaligned load, then illegal read+write
    cyc(); issue(3, 1, 0, 1, 1, 32'h102, 0); exp_q.push_back(mk(3, 0, 0, 1));
    @(negedge clk); chk("mis_stall", stall, 0);
    cyc(); issue(4, 1, 1, 1, 1, 32'h100, 0); exp_q.push_back(mk(4, 0, 0, 1));
    @(negedge clk); chk("mis_rv", req_valid, 0); chk("mis_err", err, 1); chk("ill_stall", stall, 0);
    cyc(); ctrl_valid = 0;
    @(negedge clk); chk("ill_rv", req_valid, 0); chk("ill_err", err, 1);

    // loads with random handshake delays, alternating mem_to_reg
    for (int i = 0; i < 4; i++) begin
      dr = $urandom_range(0, 2); ds = $urandom_range(0, 2);
      a = {$urandom_range(0, 32'h3FFF), 2'b00}; d = $urandom;
      cyc(); issue(5'(10 + i), 1, 0, i[0], 1, a, 0);
      exp_q.push_back(mk(5'(10 + i), i[0] ? d : a, 1, 0));
      @(negedge clk);
      cyc(); ctrl_valid = 0;
      repeat (dr) begin @(negedge clk); chk("rl_rv_hold", req_valid, 1); cyc(); end
      req_ready = 1;
      @(negedge clk); chk("rl_rv", req_valid, 1); chk("rl_addr", req_addr, {32'h0, a});
      cyc(); req_ready = 0;
      repeat (ds) begin @(negedge clk); chk("rl_wait_stall", stall, 1); cyc(); end
      rsp_valid = 1; rsp_rdata = d;
      @(negedge clk);
      cyc(); rsp_valid = 0;
      @(negedge clk); chk("rl_wb_valid", wb_valid, 1);
    end

    // reset while in WAIT abandons the access
    cyc(); issue(6, 1, 0, 1, 1, 32'h40, 0); req_ready = 1;
    cyc(); ctrl_valid = 0;
    cyc(); req_ready = 0; rst = 1;
    @(negedge clk); chk("rw_stall_wait", stall, 1);
    cyc(); rst = 0;
    @(negedge clk);
    chk("rw_outs", {req_valid, req_we, wb_valid, wb_reg_write, err}, 0);
    chk("rw_data", {req_addr, wb_data}, 0); chk("rw_stall", stall, 0);
    cyc(); rsp_valid = 1; rsp_rdata = 32'h5555;
    cyc(); rsp_valid = 0;
    @(negedge clk); chk("rw_no_wb", wb_valid, 0);

`ifdef MEM_TIMEOUT_EN
    // no response: abort after 4 WAIT cycles, late response ignored
    cyc(); issue(8, 1, 0, 1, 1, 32'h80, 0); req_ready = 1; exp_q.push_back(mk(8, 0, 0, 1));
    cyc(); ctrl_valid = 0;
    cyc(); req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("to_wait_stall", stall, 1); chk("to_no_wb", wb_valid, 0); cyc();
    end
    @(negedge clk); chk("to_wb_valid", wb_valid, 1); chk("to_err", err, 1);
    cyc(); rsp_valid = 1;
    cyc(); rsp_valid = 0;
    @(negedge clk); chk("to_late_ignored", wb_valid, 0);
`else
    // no timeout: a long WAIT still completes normally
    cyc(); issue(8, 1, 0, 1, 1, 32'h80, 0); req_ready = 1; exp_q.push_back(mk(8, 32'h77, 1, 0));
    cyc(); ctrl_valid = 0;
    cyc(); req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("lw_long_stall", stall, 1); chk("lw_long_no_err", err, 0); cyc();
    end
    rsp_valid = 1; rsp_rdata = 32'h77;
    cyc(); rsp_valid = 0;
    @(negedge clk); chk("lw_long_wb", wb_valid, 1);
`endif

    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
